// File: rtl/decode_if.sv
// Handshake and decoded-field bundle for decode_stage.
// slave: the decode stage (accepts in_*, presents out_*).
// master: the surrounding fetch/register-read side.
// The jtarget field exists only when DECODE_JTARGET_EN is defined.
interface decode_if #(
    parameter int IMM_W = 32,
    parameter int PC_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr_in;
    logic [PC_W-1:0]   pc_in;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [IMM_W-1:0]  imm_ext;
    logic [25:0]       jaddr;
    logic [PC_W-1:0]   pc_out;
`ifdef DECODE_JTARGET_EN
    logic [PC_W-1:0]   jtarget;

    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, fmt, opcode, rs, rt, rd, shamt, funct,
               imm_ext, jaddr, pc_out, jtarget
    );

    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, fmt, opcode, rs, rt, rd, shamt, funct,
               imm_ext, jaddr, pc_out, jtarget
    );
`else
    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, fmt, opcode, rs, rt, rd, shamt, funct,
               imm_ext, jaddr, pc_out
    );

    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, fmt, opcode, rs, rt, rd, shamt, funct,
               imm_ext, jaddr, pc_out
    );
`endif
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered MIPS32 instruction decode between fetch and
// register read. The word is decoded combinationally on entry, and the
// decoded record is stored in an output register backed by a one-entry skid
// register, so in_ready depends only on registered state.
// Optional feature macro: DECODE_JTARGET_EN adds the registered jump target.
module decode_stage #(
    parameter int IMM_W = 32,
    parameter int PC_W  = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    decode_if.slave  bus
);

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] FULL  = 2'b01;
    localparam logic [1:0] SKID  = 2'b10;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_J = 2'b10;

    typedef struct packed {
        logic [1:0]       fmt;
        logic [5:0]       opcode;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [5:0]       funct;
        logic [IMM_W-1:0] imm_ext;
        logic [25:0]      jaddr;
        logic [PC_W-1:0]  pc;
`ifdef DECODE_JTARGET_EN
        logic [PC_W-1:0]  jtarget;
`endif
    } entry_t;

    // Immediate extension: logical ops zero-extend, LUI shifts into the
    // upper half, everything else sign-extends.
    function automatic logic [IMM_W-1:0] ext_imm(input logic [5:0] op,
                                                  input logic [15:0] imm);
        logic [IMM_W-1:0] res;
        case (op)
            6'h0C, 6'h0D, 6'h0E: res = IMM_W'(imm);
            6'h0F:               res = IMM_W'({imm, 16'h0000});
            default:             res = IMM_W'($signed(imm));
        endcase
        return res;
    endfunction

    // Full decode of one word; fields unused by the format are forced to 0.
    function automatic entry_t decode(input logic [31:0]     ins,
                                      input logic [PC_W-1:0] pc);
        entry_t e;
`ifdef DECODE_JTARGET_EN
        logic [PC_W-1:0] pc4;
`endif
        e        = '0;
        e.opcode = ins[31:26];
        e.pc     = pc;
        if (ins[31:26] == 6'h00) begin
            e.fmt   = FMT_R;
            e.rs    = ins[25:21];
            e.rt    = ins[20:16];
            e.rd    = ins[15:11];
            e.shamt = ins[10:6];
            e.funct = ins[5:0];
        end else if (ins[31:27] == 5'b00001) begin
            e.fmt   = FMT_J;
            e.jaddr = ins[25:0];
`ifdef DECODE_JTARGET_EN
            pc4             = pc + PC_W'(4);
            e.jtarget       = pc4;
            e.jtarget[27:0] = {ins[25:0], 2'b00};
`endif
        end else begin
            e.fmt     = FMT_I;
            e.rs      = ins[25:21];
            e.rt      = ins[20:16];
            e.imm_ext = ext_imm(ins[31:26], ins[15:0]);
        end
        return e;
    endfunction

    logic [1:0] state_q;
    entry_t     dec_p0;
    entry_t     out_p1;
    entry_t     skid_p1;
    logic       in_fire;
    logic       out_fire;

    assign bus.in_ready  = (state_q != SKID) || !rst_n;
    assign bus.out_valid = (state_q != EMPTY);
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    // Stage 0: decode the incoming word ahead of either register.
    always_comb begin
        dec_p0 = decode(bus.instr_in, bus.pc_in);
    end

    // Occupancy state; reset beats flush, flush beats both handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_q <= FULL;
                FULL: begin
                    if (in_fire && !out_fire)
                        state_q <= SKID;
                    else if (!in_fire && out_fire)
                        state_q <= EMPTY;
                end
                SKID: if (out_fire) state_q <= FULL;
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Stage 1 output register: loads a new beat when empty or draining,
    // or takes the skid entry when the held beat leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_p1 <= '0;
        end else if (!flush) begin
            if (state_q == SKID) begin
                if (out_fire)
                    out_p1 <= skid_p1;
            end else if (in_fire && (state_q == EMPTY || out_fire)) begin
                out_p1 <= dec_p0;
            end
        end
    end

    // Skid register: captures the beat accepted while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && state_q == FULL && in_fire && !out_fire)
            skid_p1 <= dec_p0;
    end

    assign bus.fmt     = out_p1.fmt;
    assign bus.opcode  = out_p1.opcode;
    assign bus.rs      = out_p1.rs;
    assign bus.rt      = out_p1.rt;
    assign bus.rd      = out_p1.rd;
    assign bus.shamt   = out_p1.shamt;
    assign bus.funct   = out_p1.funct;
    assign bus.imm_ext = out_p1.imm_ext;
    assign bus.jaddr   = out_p1.jaddr;
    assign bus.pc_out  = out_p1.pc;
`ifdef DECODE_JTARGET_EN
    assign bus.jtarget = out_p1.jtarget;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus randomized traffic,
// with a scoreboard fed from accepted beats and drained by an output monitor.
`timescale 1ns/1ps
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    decode_if #(.IMM_W(32), .PC_W(32)) bus ();

    decode_stage #(.IMM_W(32), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [25:0] ja;
        logic [31:0] pc;
        logic [31:0] jt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic dir_or = 1'b0;
    logic rnd_or = 1'b0;
    logic rnd_en = 1'b0;
    assign bus.out_ready = rnd_en ? rnd_or : dir_or;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference decode straight from the MIPS field rules, using integer arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int unsigned w, op, lo;
        w  = ins;
        op = w >> 26;
        lo = w & 32'hFFFF;
        e  = '{default: 0};
        e.op = 6'(op);
        e.pc = pc;
        if (op == 0) begin
            e.fmt = 2'd0;
            e.rs  = 5'((w >> 21) & 31);
            e.rt  = 5'((w >> 16) & 31);
            e.rd  = 5'((w >> 11) & 31);
            e.sh  = 5'((w >> 6) & 31);
            e.fn  = 6'(w & 63);
        end else if (op == 2 || op == 3) begin
            e.fmt = 2'd2;
            e.ja  = 26'(w & 32'h03FF_FFFF);
            e.jt  = ((pc + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        end else begin
            e.fmt = 2'd1;
            e.rs  = 5'((w >> 21) & 31);
            e.rt  = 5'((w >> 16) & 31);
            if (op >= 12 && op <= 14)
                e.imm = lo;
            else if (op == 15)
                e.imm = lo << 16;
            else if (lo >= 32'h8000)
                e.imm = lo + 32'hFFFF_0000;
            else
                e.imm = lo;
        end
        return e;
    endfunction

    function automatic logic [127:0] pack_exp(input exp_t e);
        return 128'({e.fmt, e.op, e.rs, e.rt, e.rd, e.sh, e.fn, e.imm, e.ja, e.pc});
    endfunction

    function automatic logic [127:0] pack_dut();
        return 128'({bus.fmt, bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct,
                     bus.imm_ext, bus.jaddr, bus.pc_out});
    endfunction

    // Monitor: push accepted beats, pop and compare delivered beats, check stall stability.
    logic         prev_stall = 1'b0;
    logic [127:0] prev_snap  = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.out_valid)
                chk("hold_stable", pack_dut(), prev_snap);
            if (bus.out_valid && bus.out_ready && !flush) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat_pc", 128'(bus.pc_out), 128'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("beat_fields", pack_dut(), pack_exp(e));
`ifdef DECODE_JTARGET_EN
                    chk("beat_jtarget", 128'(bus.jtarget), 128'(e.jt));
`endif
                end
            end
            if (bus.in_valid && bus.in_ready && !flush)
                q.push_back(model(bus.instr_in, bus.pc_in));
            if (flush)
                q.delete();
            prev_stall = bus.out_valid && !bus.out_ready && !flush;
            prev_snap  = pack_dut();
        end
    end

    // Random downstream back-pressure, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        rnd_or = ($urandom_range(0, 3) != 0);
    end

    // Offer one beat and hold it until accepted (bounded).
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr_in = ins;
        bus.pc_in    = pc;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            n++;
        end
        if (!ok) chk("send_timeout", 128'(pc), 128'(~pc));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  op;
        int          sel;
        r   = $urandom();
        sel = $urandom_range(0, 7);
        case (sel)
            0:       op = 6'h00;
            1:       op = 6'(2 + $urandom_range(0, 1));
            2:       op = 6'(12 + $urandom_range(0, 3));
            default: op = 6'($urandom_range(0, 63));
        endcase
        r[31:26] = op;
        return r;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom();
        p[1:0] = 2'b00;
        return p;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        rnd_en = 1'b0;
        dir_or = 1'b1;
        while ((q.size() != 0 || bus.out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 128'(q.size()), 128'(0));
        cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr_in = '0;
        bus.pc_in    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
        chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
        chk("reset_fields", pack_dut(), 128'(0));
        cycle();
        rst_n  = 1'b1;
        dir_or = 1'b1;

        // R, I (sign/zero/LUI) and J decodes
        send(32'h0022_1820, 32'h0000_0100);
        send(32'h2008_FFFF, 32'h0000_0104);
        send(32'h3408_FFFF, 32'h0000_0108);
        send(32'h3C08_1234, 32'h0000_010C);
        send(32'h0800_0010, 32'h4000_0000);
        drain();

        // Back-pressure: A held, B in skid, C blocked
        dir_or = 1'b0;
        send(32'h0022_1820, 32'h0000_1000);
        send(32'h2008_0005, 32'h0000_1004);
        bus.in_valid = 1'b1;
        bus.instr_in = 32'h0C00_0020;
        bus.pc_in    = 32'h0000_1008;
        repeat (3) begin
            @(negedge clk);
            chk("skid_in_ready_low", 128'(bus.in_ready), 128'(0));
            chk("skid_out_holds_A", 128'(bus.pc_out), 128'(32'h0000_1000));
        end
        cycle();
        dir_or = 1'b1;
        send(32'h0C00_0020, 32'h0000_1008);
        drain();

        // Flush while in SKID with a beat offered
        dir_or = 1'b0;
        send(32'h0022_1820, 32'h0000_2000);
        send(32'h2008_0005, 32'h0000_2004);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr_in = 32'h3C08_BEEF;
        bus.pc_in    = 32'h0000_2008;
        cycle();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
        chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
        cycle();
        dir_or = 1'b1;
        repeat (4) cycle();
        drain();

        // Reset while FULL
        dir_or = 1'b0;
        send(32'h2008_FFFF, 32'h0000_3000);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_out_valid", 128'(bus.out_valid), 128'(0));
        chk("midreset_fields", pack_dut(), 128'(0));
        chk("midreset_in_ready", 128'(bus.in_ready), 128'(1));
        cycle();
        dir_or = 1'b1;
        send(32'h0800_0010, 32'h4000_0000);
        drain();

        // Randomized traffic with random back-pressure and occasional flush
        rnd_en = 1'b1;
        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                flush        = 1'b1;
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.instr_in = rand_instr();
                bus.pc_in    = rand_pc();
                cycle();
                flush        = 1'b0;
                bus.in_valid = 1'b0;
            end else if (r < 20) begin
                cycle();
            end else begin
                send(rand_instr(), rand_pc());
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
